// File: rtl/uart_params.sv
// Bit-timing parameters shared by the UART transmit and receive paths, so both
// ends derive the same bit length from the same clock and rate.
package uart_params;

  localparam int DEFAULT_BIT_RATE = 9600;
  localparam int DEFAULT_CLK_HZ   = 50_000_000;

  // Integer-truncated clock cycles per line bit.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, STOP_BITS stop bits.
// The line and busy flag are both registered, so neither can glitch.
module uart_tx
  import uart_params::*;
#(
  parameter int BIT_RATE     = DEFAULT_BIT_RATE,
  parameter int CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CW             = $clog2(CYCLES_PER_BIT + 1);
  localparam int BW             = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CW-1:0] LAST_CYCLE = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  r_state, w_state_next;
  logic [CW-1:0]           r_cycle_cnt, w_cycle_cnt_next;
  logic [BW-1:0]           r_bit_cnt, w_bit_cnt_next;
  logic [PAYLOAD_BITS-1:0] r_shift, w_shift_next, w_shifted;
  logic                    r_txd, w_txd_next;
  logic                    r_busy;
  logic                    w_bit_end;

  assign w_bit_end = (r_cycle_cnt == LAST_CYCLE);
  assign w_shifted = r_shift >> 1;

  // The bit counter is reused in STOP to count stop bits.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_next     = r_state;
    w_cycle_cnt_next = r_cycle_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_txd_next       = r_txd;

    unique case (r_state)
      IDLE: begin
        w_txd_next = 1'b1;
        if (uart_tx_en) begin
          w_shift_next     = uart_tx_data;
          w_cycle_cnt_next = '0;
          w_txd_next       = 1'b0;
          w_state_next     = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_cycle_cnt_next = '0;
          w_txd_next       = r_shift[0];
          w_state_next     = DATA;
        end else begin
          w_cycle_cnt_next = r_cycle_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cycle_cnt_next = '0;
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_next = '0;
            w_txd_next     = 1'b1;
            w_state_next   = STOP;
          end else begin
            w_shift_next   = w_shifted;
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_txd_next     = w_shifted[0];
          end
        end else begin
          w_cycle_cnt_next = r_cycle_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_cycle_cnt_next = '0;
          if (r_bit_cnt == LAST_STOP) begin
            w_bit_cnt_next = '0;
            w_state_next   = IDLE;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end else begin
          w_cycle_cnt_next = r_cycle_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_cycle_cnt <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_txd       <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state     <= w_state_next;
      r_cycle_cnt <= w_cycle_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_txd       <= w_txd_next;
      r_busy      <= (w_state_next != IDLE);
    end
  end

  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, random frames against a
// frame-level model, and hand-written reset / lockout / two-stop-bit sequences.
module tb_uart_tx;

  // Non-integer ratio (12.98) so the truncating derivation is exercised.
  localparam int CLK_HZ   = 1_000_000;
  localparam int BIT_RATE = 77_000;
  localparam int PB       = 8;
  localparam int CPB      = 12;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i is the i-th bit on the line
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] en;
  logic [7:0] data0, data1;
  logic [1:0] txd, busy;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(PB), .STOP_BITS(1)) dut0 (
    .clk(clk), .resetn(resetn), .uart_txd(txd[0]), .uart_tx_busy(busy[0]),
    .uart_tx_en(en[0]), .uart_tx_data(data0)
  );

  uart_tx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(PB), .STOP_BITS(2)) dut1 (
    .clk(clk), .resetn(resetn), .uart_txd(txd[1]), .uart_tx_busy(busy[1]),
    .uart_tx_en(en[1]), .uart_tx_data(data1)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line value n cycles after the accept edge: bit slot n/CPB of the frame.
  function automatic logic model_txd(input logic [7:0] d, input int n);
    int slot = n / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= PB) return d[slot-1];
    return 1'b1;
  endfunction

  function automatic logic model_busy(input int stop, input int n);
    return (n < (1 + PB + stop) * CPB) ? 1'b1 : 1'b0;
  endfunction

  task automatic drive(input int sel, input logic e, input logic [7:0] d);
    if (sel == 0) begin en[0] = e; data0 = d; end
    else          begin en[1] = e; data1 = d; end
  endtask

  // Called just after the accept edge; checks every cycle until busy has fallen.
  task automatic check_frame(input int sel, input logic [7:0] d, input int stop, input bit junk);
    int total = (1 + PB + stop) * CPB;
    for (int n = 0; n <= total; n++) begin
      #1;
      check($sformatf("dut%0d txd n=%0d", sel, n), txd[sel], model_txd(d, n));
      check($sformatf("dut%0d busy n=%0d", sel, n), busy[sel], model_busy(stop, n));
      @(negedge clk);
      if (junk && n < total - 2) drive(sel, 1'($urandom), 8'($urandom));
      else                       drive(sel, 1'b0, 8'($urandom));
      @(posedge clk);
    end
  endtask

  task automatic send(input int sel, input logic [7:0] d, input int stop, input bit junk);
    @(negedge clk);
    check($sformatf("dut%0d ready before send", sel), busy[sel], 1'b0);
    drive(sel, 1'b1, d);
    @(posedge clk);
    check_frame(sel, d, stop, junk);
  endtask

  initial begin
    vec_t tbl[4];
    tbl[0] = '{data: 8'hA5, frame: 10'b1101001010};
    tbl[1] = '{data: 8'h00, frame: 10'b1000000000};
    tbl[2] = '{data: 8'hFF, frame: 10'b1111111110};
    tbl[3] = '{data: 8'h3C, frame: 10'b1001111000};

    // Reset held with requests pending: line idle, no busy.
    resetn = 1'b0;
    drive(0, 1'b1, 8'hA5);
    drive(1, 1'b1, 8'h81);
    repeat (4) begin
      @(posedge clk); #1;
      check("reset txd0", txd[0], 1'b1);
      check("reset busy0", busy[0], 1'b0);
      check("reset txd1", txd[1], 1'b1);
      check("reset busy1", busy[1], 1'b0);
    end
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 1'b0, 8'h00);
    @(posedge clk);
    check_frame(0, 8'hA5, 1, 1'b0);

    // Table vectors: mid-bit samples and exact busy fall.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1'b1, tbl[i].data);
      @(posedge clk);
      for (int n = 0; n <= 120; n++) begin
        #1;
        if (n == 0) begin
          check($sformatf("tbl%0d start latency txd", i), txd[0], 1'b0);
          check($sformatf("tbl%0d start latency busy", i), busy[0], 1'b1);
        end
        if (n % CPB == CPB / 2)
          check($sformatf("tbl%0d midbit %0d", i, n / CPB), txd[0], tbl[i].frame[n/CPB]);
        if (n == 119) check($sformatf("tbl%0d busy last cycle", i), busy[0], 1'b1);
        if (n == 120) check($sformatf("tbl%0d busy fall", i), busy[0], 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        @(posedge clk);
      end
    end

    // Busy lockout: en held, data changed mid-frame; next frame 121 cycles later.
    @(negedge clk);
    drive(0, 1'b1, 8'h3C);
    @(posedge clk);
    for (int n = 0; n <= 241; n++) begin
      #1;
      if (n <= 120) begin
        check($sformatf("lockout 3C txd n=%0d", n), txd[0], model_txd(8'h3C, n));
        check($sformatf("lockout 3C busy n=%0d", n), busy[0], model_busy(1, n));
      end else begin
        check($sformatf("lockout FF txd n=%0d", n), txd[0], model_txd(8'hFF, n - 121));
        check($sformatf("lockout FF busy n=%0d", n), busy[0], model_busy(1, n - 121));
      end
      @(negedge clk);
      if (n == 50)  drive(0, 1'b1, 8'hFF);
      if (n == 130) drive(0, 1'b0, 8'h00);
      @(posedge clk);
    end

    // Reset during data bit 3 of 0xF0 (a low bit), then a clean 0x55 frame.
    @(negedge clk);
    drive(0, 1'b1, 8'hF0);
    @(posedge clk);
    for (int n = 0; n < 53; n++) begin
      #1;
      check($sformatf("prereset txd n=%0d", n), txd[0], model_txd(8'hF0, n));
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      @(posedge clk);
    end
    #1;
    check("data bit 3 low before reset", txd[0], 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset txd", txd[0], 1'b1);
    check("async reset busy", busy[0], 1'b0);
    @(posedge clk); #1;
    check("reset held txd", txd[0], 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("frame abandoned busy", busy[0], 1'b0);
    send(0, 8'h55, 1, 1'b0);

    // Two stop bits: busy falls 132 cycles after accept.
    send(1, 8'h81, 2, 1'b0);

    // Random frames on both instances with junk requests during each frame.
    for (int i = 0; i < 20; i++) begin
      int sel = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(sel, 8'($urandom), sel + 1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises a parallel payload onto a single TX line as start bit, LSB-first data, stop bit(s). It sits downstream of the system logic and is the transmit-side companion of `uart_rx` inside `impl_top`, for example to echo received bytes back to the host. It shares the clock and reset domain of `uart_rx` and uses the same bit-timing derivation.

## Interface
Parameters:
- `BIT_RATE`, 9600: line bit rate, bits/s.
- `CLK_HZ`, 50_000_000: system clock frequency, Hz.
- `PAYLOAD_BITS`, 8: data bits per frame.
- `STOP_BITS`, 1: stop bits per frame (1 or 2).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, all state on rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `uart_txd` out 1: serial line, idle high.
- `uart_tx_busy` out 1: high while a frame is in progress; low means ready.
- `uart_tx_en` in 1: send request, sampled only when `uart_tx_busy` is low.
- `uart_tx_data` in PAYLOAD_BITS: payload, captured in the same cycle `uart_tx_en` is accepted.

## Operation
- Derived constant: CYCLES_PER_BIT = CLK_HZ / BIT_RATE, integer-truncated. The default is 5208.
- Cycle counter width: $clog2(CYCLES_PER_BIT+1). Bit counter width: $clog2(PAYLOAD_BITS+1).
- States:
  - IDLE: `uart_txd`=1, busy=0. If `uart_tx_en`=1, capture `uart_tx_data` into the shift register and go to START.
  - START: `uart_txd`=0 for CYCLES_PER_BIT cycles, then go to DATA.
  - DATA: `uart_txd`=shift[0]. Each bit lasts CYCLES_PER_BIT cycles. At the end of each bit, shift right and increment the bit counter. After PAYLOAD_BITS bits, go to STOP.
  - STOP: `uart_txd`=1 for STOP_BITS×CYCLES_PER_BIT cycles, then go to IDLE.
- `uart_txd` is a registered output and is glitch-free; it changes only at bit boundaries.
- `uart_tx_en` asserted in START/DATA/STOP is ignored. There is no queueing and no error flag.
- Changes to `uart_tx_data` after acceptance have no effect on the frame in progress.
- Reset values: state=IDLE, `uart_txd`=1, `uart_tx_busy`=0, counters=0, shift register=0.
- Reset mid-frame: the line returns high immediately (asynchronously). The partial frame is abandoned and not resumed.

## Timing
- Accept edge E: `uart_tx_en`=1 and busy=0 at rising edge E.
- After edge E, `uart_txd`=0 and `uart_tx_busy`=1, both registered (latency 1 cycle).
- The start bit occupies exactly CYCLES_PER_BIT cycles. Data bit k begins (1+k)×CYCLES_PER_BIT cycles after edge E.
- Busy falls exactly (1+PAYLOAD_BITS+STOP_BITS)×CYCLES_PER_BIT cycles after edge E, which is 52080 cycles for the default parameters.
- The first edge at which busy is low may accept the next request. Back-to-back frames are therefore spaced (1+PAYLOAD_BITS+STOP_BITS)×CYCLES_PER_BIT+1 cycles, with one extra high idle cycle between frames.
- `uart_tx_busy` is a registered function of state (busy = state≠IDLE). There is no combinational path from `uart_tx_en` to any output.

## Structure
- Shared package/include `uart_params` holds:
  - the BIT_RATE/CLK_HZ defaults;
  - the CYCLES_PER_BIT derivation, identical to `uart_rx` so both ends agree on bit length.
- The state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3) is local to `uart_tx`.
- No sub-module: a single module with an FSM, a cycle counter, a bit counter and a shift register. The target size is about 150 lines.

## Test plan
Parameters for all tests: CLK_HZ=50_000_000, BIT_RATE=9600 (CYCLES_PER_BIT=5208, 20 ns clock).
- Reset: hold `resetn`=0 with `uart_tx_en`=1 -> `uart_txd`=1 and busy=0 throughout. Release reset -> the frame starts on the first edge with `uart_tx_en` high.
- Single byte 0xA5: pulse `uart_tx_en` for 1 cycle ->
  - `uart_txd` low 1 cycle later;
  - sampling at mid-bit (2604+5208k cycles) yields 0, 1,0,1,0,0,1,0,1, 1;
  - busy falls 52080 cycles after accept.
- Loopback: drive `uart_txd` into `uart_rxd` of `impl_top` and send bytes 0x00..0xFE -> each received `data` equals the sent byte.
- Busy lockout: hold `uart_tx_en`=1 with data 0x3C, then change data to 0xFF mid-frame -> the transmitted frame is 0x3C. The next frame (0xFF) starts exactly 52081 cycles after the first accept.
- Reset mid-frame: assert `resetn`=0 during data bit 3 -> `uart_txd`=1 and busy=0 immediately. A new 0x55 request after release produces a complete, correct frame.
- STOP_BITS=2: send 0x81 -> the line is high for 10416 cycles after the last data bit, and busy falls 57288 cycles after accept.
